udp_payload_pkt_fifo: RTL and testbench
=======================================

// Module: udp_payload_pkt_fifo
// PURPOSE
//  Store-and-forward packet FIFO placed directly downstream of the UDP filter payload output.
//  Buffers each UDP payload frame in full and releases it to the consumer only after its tlast word is written.
//  Drops, as a whole, any frame that cannot fit, so the consumer never sees a truncated frame.
//  The filter is therefore never back-pressured mid-frame.
// PARAMETERS
//  STREAM_DATA_WIDTH  32   payload word width; keep width = STREAM_DATA_WIDTH/8
//  FIFO_DEPTH         512  words of storage, power of two
//  MAX_PACKETS        16   maximum number of committed frames held at once
// PORTS
//  clk_i            in   1      single clock
//  a_rst_n_i        in   1      reset, asynchronous assert, active-low
//  s_axis_tdata_i   in   SDW    payload word from the UDP filter
//  s_axis_tkeep_i   in   SDW/8  byte enables
//  s_axis_tvalid_i  in   1      write-side valid
//  s_axis_tlast_i   in   1      last word of the frame
//  s_axis_tready_o  out  1      write-side ready
//  m_axis_tdata_o   out  SDW    buffered payload word
//  m_axis_tkeep_o   out  SDW/8  byte enables, stored alongside the data
//  m_axis_tvalid_o  out  1      read-side valid
//  m_axis_tlast_o   out  1      last word of the frame, stored alongside the data
//  m_axis_tready_i  in   1      consumer ready
// BEHAVIOUR
//  Reset values: all m_axis outputs 0; s_axis_tready_o 0 during reset, 1 from the first clock after release.
//  Reset state: all pointers 0, pkt_cnt 0, write FSM in WR_IDLE.
//  Pointers: wr_ptr, commit_ptr and rd_ptr are each log2(FIFO_DEPTH)+1 bits.
//   used = wr_ptr - rd_ptr (modular); full = (used == FIFO_DEPTH); pointers wrap naturally.
//  Write FSM, evaluated on each accepted beat (s_tvalid & s_tready):
//   WR_IDLE: if pkt_cnt == MAX_PACKETS or full -> go WR_DROP, word discarded.
//            else write {tlast, tkeep, tdata} at wr_ptr and increment wr_ptr.
//            If tlast, commit; otherwise go WR_STORE.
//   WR_STORE: if full, set wr_ptr <= commit_ptr (rollback) and go WR_DROP.
//             else write the word; on tlast, commit and go WR_IDLE.
//   WR_DROP: discard words; on tlast go WR_IDLE.
//   commit: commit_ptr <= wr_ptr + 1 (the pointer value after the tlast write); pkt_cnt increments.
//  s_axis_tready_o is 1 whenever out of reset. Back-pressure never reaches the filter; overflow is handled by dropping.
//  Read side:
//   RAM has registered read (1 cycle), followed by one output register stage.
//   Fetch when rd_ptr != commit_ptr and the output stage is empty or is handshaking this cycle.
//   Only committed words are ever read.
//  Latency: a tlast accepted at cycle N makes the first word of that frame valid at N+3 at the earliest
//   (N+1 commit visible, N+2 RAM read, N+3 output register).
//  Throughput: one word per clock sustained on both sides.
//  m_axis holds data, keep and last stable while tvalid=1 and tready=0.
//  pkt_cnt decrements on an m_axis handshake with tlast=1.
//   Commit and read-tlast in the same cycle: pkt_cnt unchanged.
//  Frame boundaries:
//   A single-word frame (tvalid & tlast on one beat) is a legal frame.
//   A frame larger than FIFO_DEPTH is always dropped.
//  Reset mid-operation: partial and committed frames are discarded, m_axis_tvalid_o drops immediately.
// CONFIGURATION
//  Macro: UDP_PKT_FIFO_STATS_EN.
//  When defined, adds the following ports, all reset to 0:
//   drop_cnt_o  out 16  frames dropped, saturating at 16'hFFFF
//   pkt_cnt_o   out log2(MAX_PACKETS)+1  committed frames currently held
//   overflow_o  out 1   one-cycle pulse on each WR_IDLE/WR_STORE -> WR_DROP transition
//  When undefined, these ports and their logic are absent; datapath behaviour is identical.
// STRUCTURE
//  udp_pkt_fifo.vh holds shared definitions:
//   write-FSM state encodings WR_IDLE=0, WR_STORE=1, WR_DROP=2, and WR_STATE_WIDTH=2;
//   the stored-word width macro (SDW + SDW/8 + 1).
//  One sub-module, sdp_ram: simple dual-port RAM with one write port, one registered read port and parameterised width/depth.
//  The top level holds the write FSM, the pointers, pkt_cnt and the output register.
// TESTING
//  1 Frame of 4 words, tdata 0x11..0x44, keep 0xF, consumer ready:
//    -> same 4 words out, tlast on word 4, first word valid 3 cycles after tlast in.
//  2 Back-to-back frames of 1, 2 and 3 words; consumer tready toggles every cycle:
//    -> all words out in order, data stable while stalled, pkt_cnt returns to 0.
//  3 DEPTH=16; write a 10-word frame, then a 10-word frame with no reads:
//    -> second frame overflows at word 7, is rolled back and dropped;
//       output shows only the first frame; drop_cnt_o=1 (STATS_EN).
//  4 MAX_PACKETS=2; write 3 one-word frames with no reads:
//    -> third frame dropped; after reading, exactly 2 frames appear.
//  5 Last word of frame A is written in the same cycle that frame B's tlast is read out:
//    -> pkt_cnt unchanged; frame A follows B intact.
//  6 Assert a_rst_n_i mid-frame on both sides:
//    -> outputs 0 asynchronously; after release, a new 2-word frame passes correctly.

Source files
------------

// File: rtl/udp_payload_pkt_fifo_pkg.sv
// Shared write-FSM encodings and stored-word sizing for the UDP payload packet FIFO.
package udp_payload_pkt_fifo_pkg;

    localparam int WR_STATE_WIDTH = 2;

    typedef enum logic [WR_STATE_WIDTH-1:0] {
        WR_IDLE  = 2'd0,
        WR_STORE = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_e;

    // Each RAM entry holds {tlast, tkeep, tdata}.
    function automatic int stored_word_width(input int sdw);
        return sdw + sdw / 8 + 1;
    endfunction

endpackage

// File: rtl/udp_payload_pkt_fifo_if.sv
// AXI-Stream style payload bus between the UDP filter, the packet FIFO and its consumer.
interface udp_payload_pkt_fifo_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/udp_payload_pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Latency: read data appears one clock after rd_en.
// Backpressure: none; the caller only asserts rd_en when the data can be taken.
module udp_payload_pkt_fifo_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_payload_pkt_fifo.sv
// Store-and-forward UDP payload frame FIFO; whole frames that do not fit are dropped (stats via UDP_PKT_FIFO_STATS_EN).
// Latency: first word valid 3 cycles after the cycle its frame's tlast is presented.
// Backpressure: s_axis tready is always 1 out of reset; m_axis stalls hold data stable.
module udp_payload_pkt_fifo
    import udp_payload_pkt_fifo_pkg::*;
#(
    parameter int STREAM_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH        = 512,
    parameter int MAX_PACKETS       = 16
) (
    input  logic                          clk_i,
    input  logic                          a_rst_n_i,
    udp_payload_pkt_fifo_if.slave         s_axis,
    udp_payload_pkt_fifo_if.master        m_axis
`ifdef UDP_PKT_FIFO_STATS_EN
    ,
    output logic [15:0]                   drop_cnt_o,
    output logic [$clog2(MAX_PACKETS):0]  pkt_cnt_o,
    output logic                          overflow_o
`endif
);

    localparam int SDW = STREAM_DATA_WIDTH;
    localparam int KW  = SDW / 8;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(MAX_PACKETS) + 1;
    localparam int WW  = stored_word_width(SDW);

    logic            s_rdy;
    wr_state_e       wr_state, wr_state_nxt;
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt, commit_ptr, rd_ptr;
    logic [PW-1:0]   used;
    logic [CW-1:0]   pkt_cnt;
    logic            full, idle_blocked;
    logic            accept, wr_en, commit;
    logic [WW-1:0]   wr_word, rd_word;

    logic            rd_en, ram_vld, stage_adv, out_hs;
    logic            out_vld, out_last;
    logic [KW-1:0]   out_keep;
    logic [SDW-1:0]  out_dat;

    assign s_axis.tready = s_rdy;
    assign accept        = s_axis.tvalid & s_rdy;
    assign used          = wr_ptr - rd_ptr;
    assign full          = (used == PW'(FIFO_DEPTH));
    assign idle_blocked  = (pkt_cnt == CW'(MAX_PACKETS)) | full;
    assign wr_word       = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

    // A dropped beat that is itself tlast ends the frame, so the FSM returns
    // to WR_IDLE instead of swallowing the following frame in WR_DROP.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_ptr_nxt   = wr_ptr;
        wr_en        = 1'b0;
        commit       = 1'b0;
        if (accept) begin
            case (wr_state)
                WR_IDLE: begin
                    if (idle_blocked) begin
                        if (!s_axis.tlast) begin
                            wr_state_nxt = WR_DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        if (s_axis.tlast) begin
                            commit = 1'b1;
                        end else begin
                            wr_state_nxt = WR_STORE;
                        end
                    end
                end
                WR_STORE: begin
                    if (full) begin
                        wr_ptr_nxt   = commit_ptr;
                        wr_state_nxt = s_axis.tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        if (s_axis.tlast) begin
                            commit       = 1'b1;
                            wr_state_nxt = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis.tlast) begin
                        wr_state_nxt = WR_IDLE;
                    end
                end
                default: wr_state_nxt = WR_IDLE;
            endcase
        end
    end

    udp_payload_pkt_fifo_sdp_ram #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_dat  (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_dat  (rd_word)
    );

    // Two-stage read pipe: RAM output register, then the m_axis register.
    assign out_hs    = out_vld & m_axis.tready;
    assign stage_adv = ram_vld & (~out_vld | out_hs);
    assign rd_en     = (rd_ptr != commit_ptr) & (~ram_vld | stage_adv);

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            s_rdy      <= 1'b0;
            wr_state   <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            ram_vld    <= 1'b0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
            out_keep   <= '0;
            out_dat    <= '0;
        end else begin
            s_rdy    <= 1'b1;
            wr_state <= wr_state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            if (commit) begin
                commit_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({commit, out_hs & out_last})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (rd_en) begin
                ram_vld <= 1'b1;
            end else if (stage_adv) begin
                ram_vld <= 1'b0;
            end
            if (stage_adv) begin
                out_vld                       <= 1'b1;
                {out_last, out_keep, out_dat} <= rd_word;
            end else if (out_hs) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = out_vld;
    assign m_axis.tlast  = out_last;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tdata  = out_dat;

`ifdef UDP_PKT_FIFO_STATS_EN
    logic        drop;
    logic [15:0] drop_cnt;
    logic        overflow_q;

    assign drop = accept & (((wr_state == WR_IDLE) & idle_blocked) |
                            ((wr_state == WR_STORE) & full));

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            drop_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign drop_cnt_o = drop_cnt;
    assign pkt_cnt_o  = pkt_cnt;
    assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_udp_payload_pkt_fifo.sv
// Scoreboard bench for udp_payload_pkt_fifo with a 16-word, 4-frame configuration.
module tb_udp_payload_pkt_fifo;

    localparam int SDW   = 32;
    localparam int DEPTH = 16;
    localparam int MAXP  = 4;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] dat;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;

    udp_payload_pkt_fifo_if #(.DATA_WIDTH(SDW)) s_if ();
    udp_payload_pkt_fifo_if #(.DATA_WIDTH(SDW)) m_if ();

`ifdef UDP_PKT_FIFO_STATS_EN
    logic [15:0]             drop_cnt;
    logic [$clog2(MAXP):0]   pkt_cnt_o;
    logic                    overflow;
`endif

    udp_payload_pkt_fifo #(
        .STREAM_DATA_WIDTH (SDW),
        .FIFO_DEPTH        (DEPTH),
        .MAX_PACKETS       (MAXP)
    ) dut (
        .clk_i     (clk),
        .a_rst_n_i (rst_n),
        .s_axis    (s_if),
        .m_axis    (m_if)
`ifdef UDP_PKT_FIFO_STATS_EN
        ,
        .drop_cnt_o (drop_cnt),
        .pkt_cnt_o  (pkt_cnt_o),
        .overflow_o (overflow)
`endif
    );

    initial forever #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    tlast_cyc = 0;
    int    first_vld_cyc = -1;
    bit    toggle_en = 0;
    word_t exp_q[$];
    word_t mon_got, mon_exp, held;
    logic  held_vld = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every output handshake, checks stall stability.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held_vld = 1'b0;
        end else begin
            mon_got = {m_if.tlast, m_if.tkeep, m_if.tdata};
            if (m_if.tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (held_vld) begin
                checks++;
                if (!m_if.tvalid || mon_got != held) begin
                    failures++;
                    $display("FAIL stall_hold got vld=%0b word=%h want vld=1 word=%h",
                             m_if.tvalid, mon_got, held);
                end
            end
            held_vld = m_if.tvalid && !m_if.tready;
            held     = mon_got;
            if (m_if.tvalid && m_if.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word got last=%0b keep=%h data=%h want none",
                             mon_got.last, mon_got.keep, mon_got.dat);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got != mon_exp) begin
                        failures++;
                        $display("FAIL out_word got last=%0b keep=%h data=%h want last=%0b keep=%h data=%h",
                                 mon_got.last, mon_got.keep, mon_got.dat,
                                 mon_exp.last, mon_exp.keep, mon_exp.dat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (toggle_en) m_if.tready = ~m_if.tready;
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        if (l) tlast_cyc = cyc;
        step();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Words are base, base+stride, ...; keep is 0xF except k on the last word.
    task automatic frame(input int n, input logic [31:0] base, input logic [31:0] stride,
                         input logic [3:0] k, input bit keep_it);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            logic [3:0]  kk;
            logic        l;
            d  = base + 32'(i) * stride;
            l  = (i == n - 1);
            kk = l ? k : 4'hF;
            if (keep_it) exp_q.push_back({l, kk, d});
            beat(d, kk, l);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
        step(3);
    endtask

    initial begin
        rst_n       = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_pkt_cnt", dut.pkt_cnt, 0);
        #20 rst_n = 1'b1;
        step();
        chk("post_rst_s_tready", s_if.tready, 1);

        // 1: four-word frame, consumer ready, latency from tlast.
        m_if.tready   = 1'b1;
        first_vld_cyc = -1;
        frame(4, 32'h11, 32'h11, 4'hF, 1);
        drain("t1");
        chk("t1_latency", first_vld_cyc - tlast_cyc, 3);

        // 2: back-to-back 1/2/3-word frames with tready toggling every cycle.
        toggle_en = 1;
        frame(1, 32'hA000_0000, 1, 4'h1, 1);
        frame(2, 32'hB000_0000, 1, 4'h3, 1);
        frame(3, 32'hC000_0000, 1, 4'h7, 1);
        drain("t2");
        toggle_en   = 0;
        m_if.tready = 1'b1;
        step(3);
        chk("t2_pkt_cnt", dut.pkt_cnt, 0);

        // 3: second 10-word frame overflows with no reads and is rolled back.
        m_if.tready = 1'b0;
        frame(10, 32'h3000_0000, 1, 4'hF, 1);
        frame(10, 32'h3100_0000, 1, 4'hF, 0);
        step(4);
        chk("t3_pkt_cnt_held", dut.pkt_cnt, 1);
`ifdef UDP_PKT_FIFO_STATS_EN
        chk("t3_drop_cnt", drop_cnt, 1);
`endif
        m_if.tready = 1'b1;
        drain("t3");
        step(20);
        chk("t3_pkt_cnt_end", dut.pkt_cnt, 0);

        // Depth boundary: exactly DEPTH words fits, DEPTH+1 is dropped.
        frame(16, 32'h4000_0000, 1, 4'h8, 1);
        drain("bnd16");
        frame(17, 32'h5000_0000, 1, 4'hF, 0);
        frame(2, 32'h5100_0000, 1, 4'h3, 1);
        drain("bnd17");
`ifdef UDP_PKT_FIFO_STATS_EN
        chk("bnd_drop_cnt", drop_cnt, 2);
`endif

        // 4: five single-word frames with no reads; only MAXP are kept.
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame(1, 32'h6000_0000 + 32'(i), 1, 4'(i + 1), (i < MAXP));
        end
        step(4);
        chk("t4_pkt_cnt_full", dut.pkt_cnt, MAXP);
`ifdef UDP_PKT_FIFO_STATS_EN
        chk("t4_drop_cnt", drop_cnt, 3);
`endif
        m_if.tready = 1'b1;
        drain("t4");
        step(10);
        chk("t4_pkt_cnt_end", dut.pkt_cnt, 0);
        frame(1, 32'h6100_0000, 1, 4'h2, 1);
        drain("t4_recover");

        // 5: commit of frame A coincides with the read handshake of B's tlast.
        m_if.tready = 1'b0;
        frame(1, 32'h7000_0000, 1, 4'h5, 1);
        step(5);
        chk("t5_pkt_cnt_b", dut.pkt_cnt, 1);
        exp_q.push_back({1'b0, 4'hF, 32'h7100_0000});
        beat(32'h7100_0000, 4'hF, 1'b0);
        exp_q.push_back({1'b0, 4'hF, 32'h7100_0001});
        beat(32'h7100_0001, 4'hF, 1'b0);
        exp_q.push_back({1'b1, 4'h9, 32'h7100_0002});
        m_if.tready = 1'b1;
        beat(32'h7100_0002, 4'h9, 1'b1);
        chk("t5_pkt_cnt_same", dut.pkt_cnt, 1);
        drain("t5");
        chk("t5_pkt_cnt_end", dut.pkt_cnt, 0);

        // 6: reset with a committed frame on the output and a partial frame in.
        m_if.tready = 1'b0;
        frame(2, 32'h8000_0000, 1, 4'hF, 0);
        step(4);
        chk("t6_pre_vld", m_if.tvalid, 1);
        beat(32'h9000_0000, 4'hF, 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h9000_0001;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_m_tvalid", m_if.tvalid, 0);
        chk("t6_rst_m_tdata", m_if.tdata, 0);
        chk("t6_rst_m_tkeep", m_if.tkeep, 0);
        chk("t6_rst_s_tready", s_if.tready, 0);
        s_if.tvalid = 1'b0;
        exp_q.delete();
        step(2);
        #2 rst_n = 1'b1;
        step();
        chk("t6_post_s_tready", s_if.tready, 1);
        chk("t6_post_pkt_cnt", dut.pkt_cnt, 0);
        m_if.tready = 1'b1;
        frame(2, 32'hD000_0000, 1, 4'hC, 1);
        drain("t6");
        chk("t6_pkt_cnt_end", dut.pkt_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
